// File: rtl/clk_gen_unit.sv
// Reference-clock divider producing a 50% duty square wave with rise/fall strobes,
// a completed-period counter and an optional self-stop after MAX_CYCLES periods.
module clk_gen_unit #(
  parameter int unsigned HALF_PERIOD = 1,
  parameter int unsigned CNT_W       = 16,
  parameter bit          INIT_LEVEL  = 1'b0,
  parameter int unsigned MAX_CYCLES  = 0,
  parameter int unsigned CYC_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic             clk_o,
  output logic             rise_o,
  output logic             fall_o,
  output logic [CYC_W-1:0] cycles_o,
  output logic             done_o
);

  // Elaboration-time guards on the half-period setting.
  if (HALF_PERIOD == 0) begin : g_bad_half_period
    $error("clk_gen_unit: HALF_PERIOD must be at least 1");
  end
  if (64'(HALF_PERIOD) > ((64'd1 << CNT_W) - 64'd1)) begin : g_half_period_too_wide
    $error("clk_gen_unit: HALF_PERIOD does not fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(HALF_PERIOD - 1);
  localparam logic [CYC_W-1:0] CYC_STOP  = CYC_W'(MAX_CYCLES);
  localparam bit               AUTO_STOP = (MAX_CYCLES != 0);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  state_t             state_reg,  state_next;
  logic [CNT_W-1:0]   cnt_reg,    cnt_next;
  logic               level_reg,  level_next;
  logic               rise_reg,   rise_next;
  logic               fall_reg,   fall_next;
  logic [CYC_W-1:0]   cycles_reg, cycles_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_RUN;
      cnt_reg    <= '0;
      level_reg  <= INIT_LEVEL;
      rise_reg   <= 1'b0;
      fall_reg   <= 1'b0;
      cycles_reg <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      level_reg  <= level_next;
      rise_reg   <= rise_next;
      fall_reg   <= fall_next;
      cycles_reg <= cycles_next;
    end
  end

  // Strobes default low so a disabled or stopped cycle never repeats one.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    level_next  = level_reg;
    rise_next   = 1'b0;
    fall_next   = 1'b0;
    cycles_next = cycles_reg;
    case (state_reg)
      ST_RUN: begin
        if (en) begin
          if (cnt_reg == CNT_LAST) begin
            cnt_next   = '0;
            level_next = ~level_reg;
            if (!level_reg) begin
              rise_next   = 1'b1;
              cycles_next = cycles_reg + CYC_W'(1);
            end else begin
              fall_next = 1'b1;
              // The falling edge closes the period that the last rise counted.
              if (AUTO_STOP && (cycles_reg == CYC_STOP)) begin
                state_next = ST_DONE;
              end
            end
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_next = ST_DONE;
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  assign clk_o    = level_reg;
  assign rise_o   = rise_reg;
  assign fall_o   = fall_reg;
  assign cycles_o = cycles_reg;
  assign done_o   = (state_reg == ST_DONE);

endmodule

// File: tb/tb_clk_gen_unit.sv
// Scoreboard bench: five divider configurations share clock and reset, each with its own
// random enable; expected outputs come from a closed-form model of enabled-edge counts.
module tb_clk_gen_unit;

  localparam int N     = 5;
  localparam int NCYC  = 1600;
  localparam int RST_A = 800;
  localparam int RST_B = 1300;

  function automatic int hp_of(int i);
    if (i == 1) return 3;
    if (i == 2) return 2;
    return 1;
  endfunction

  function automatic int init_of(int i);
    if (i == 2 || i == 4) return 1;
    return 0;
  endfunction

  function automatic int max_of(int i);
    if (i == 2) return 3;
    if (i == 3) return 4;
    return 0;
  endfunction

  function automatic int cw_of(int i);
    if (i == 0) return 8;
    return 32;
  endfunction

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      en;
  logic [N-1:0]      clk_o_v;
  logic [N-1:0]      rise_v;
  logic [N-1:0]      fall_v;
  logic [N-1:0]      done_v;
  logic [31:0]       cyc_v [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    logic [cw_of(gi)-1:0] cyc;
    clk_gen_unit #(
      .HALF_PERIOD(hp_of(gi)),
      .CNT_W      (16),
      .INIT_LEVEL (init_of(gi) == 1),
      .MAX_CYCLES (max_of(gi)),
      .CYC_W      (cw_of(gi))
    ) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en[gi]),
      .clk_o   (clk_o_v[gi]),
      .rise_o  (rise_v[gi]),
      .fall_o  (fall_v[gi]),
      .cycles_o(cyc),
      .done_o  (done_v[gi])
    );
    assign cyc_v[gi] = 32'(cyc);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: everything follows from k, the number of enabled edges since reset.
  function automatic int toggles(int i, int k);
    return k / hp_of(i);
  endfunction

  function automatic logic m_level(int i, int k);
    return logic'((init_of(i) + toggles(i, k)) % 2);
  endfunction

  function automatic logic [31:0] m_cycles(int i, int k);
    int t;
    int c;
    t = toggles(i, k);
    c = (init_of(i) == 0) ? (t + 1) / 2 : t / 2;
    if (cw_of(i) < 32) c = c % (1 << cw_of(i));
    return 32'(c);
  endfunction

  function automatic logic m_done(int i, int k);
    int stop_t;
    if (max_of(i) == 0) return 1'b0;
    stop_t = (init_of(i) == 0) ? 2 * max_of(i) : 2 * max_of(i) + 1;
    return toggles(i, k) >= stop_t;
  endfunction

  typedef struct packed {
    logic [N-1:0]       lvl;
    logic [N-1:0]       rise;
    logic [N-1:0]       fall;
    logic [N-1:0]       done;
    logic [N-1:0][31:0] cyc;
    int                 edge_no;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(string name, int i, int edge_no, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d edge %0d got %0h want %0h", name, i, edge_no, act, exp);
    end
  endtask

  task automatic check_reset_now(int tag);
    for (int i = 0; i < N; i++) begin
      check("async_rst_clk_o", i, tag, 32'(clk_o_v[i]), 32'(init_of(i)));
      check("async_rst_rise", i, tag, 32'(rise_v[i]), 32'd0);
      check("async_rst_fall", i, tag, 32'(fall_v[i]), 32'd0);
      check("async_rst_cycles", i, tag, cyc_v[i], 32'd0);
      check("async_rst_done", i, tag, 32'(done_v[i]), 32'd0);
    end
  endtask

  // Monitor: one expected record per clock edge, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        for (int i = 0; i < N; i++) begin
          check("clk_o", i, e.edge_no, 32'(clk_o_v[i]), 32'(e.lvl[i]));
          check("rise_o", i, e.edge_no, 32'(rise_v[i]), 32'(e.rise[i]));
          check("fall_o", i, e.edge_no, 32'(fall_v[i]), 32'(e.fall[i]));
          check("cycles_o", i, e.edge_no, cyc_v[i], e.cyc[i]);
          check("done_o", i, e.edge_no, 32'(done_v[i]), 32'(e.done[i]));
        end
      end
    end
  end

  // Stimulus and model update.
  initial begin
    int   k [N];
    exp_t e;
    logic tog;
    for (int i = 0; i < N; i++) k[i] = 0;
    rst_n = 1'b1;
    en    = '0;
    #1 rst_n = 1'b0;
    #1 check_reset_now(-1);

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      e = '0;
      e.edge_no = cyc;
      for (int i = 0; i < N; i++) begin
        tog = 1'b0;
        if (!rst_n) begin
          k[i] = 0;
        end else if (en[i] && !m_done(i, k[i])) begin
          k[i] = k[i] + 1;
          tog  = (k[i] % hp_of(i)) == 0;
        end
        e.lvl[i]  = m_level(i, k[i]);
        e.rise[i] = tog && m_level(i, k[i]);
        e.fall[i] = tog && !m_level(i, k[i]);
        e.cyc[i]  = m_cycles(i, k[i]);
        e.done[i] = m_done(i, k[i]);
      end
      sb.push_back(e);

      #2;
      if (cyc == 2 || cyc == RST_A + 1 || cyc == RST_B + 1) rst_n = 1'b1;
      if (cyc < 40) begin
        en = '1;
      end else begin
        for (int i = 0; i < N; i++) en[i] = ($urandom_range(3) != 0);
      end
      if (cyc == RST_A || cyc == RST_B) begin
        #1 rst_n = 1'b0;
        #1 check_reset_now(cyc);
      end
    end

    @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_gen_unit.md
Name: clk_gen_unit

Overview:
- Synchronous clock generator/divider driving a free-running square wave for downstream inverter chains and mixed-signal co-simulation stimulus.
- Toggles its output every HALF_PERIOD reference-clock cycles.
- Provides rise/fall strobes and a completed-period counter.
- Can stop itself after a programmed number of periods.

Parameters:
- HALF_PERIOD, 1, reference cycles per output half-period; legal range 1..2^CNT_W-1.
- CNT_W, 16, width of the internal half-period counter.
- INIT_LEVEL, 0, level of clk_o after reset.
- MAX_CYCLES, 0, number of full output periods before auto-stop; 0 = run forever.
- CYC_W, 32, width of cycles_o.

Ports:
- clk  input  1  reference clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  run enable; low freezes all state.
- clk_o  output  1  generated clock, registered.
- rise_o  output  1  one-cycle strobe, high in the cycle clk_o first reads 1.
- fall_o  output  1  one-cycle strobe, high in the cycle clk_o first reads 0.
- cycles_o  output  CYC_W  count of rising transitions of clk_o since reset.
- done_o  output  1  high once MAX_CYCLES periods have completed (MAX_CYCLES>0 only).

Behaviour:
- Reset (rst_n low, asynchronous, no clock needed):
  - clk_o=INIT_LEVEL, internal cnt=0.
  - rise_o=0, fall_o=0, cycles_o=0, done_o=0.
- Deassertion of reset takes effect on the next rising clk edge.
- Each rising edge with en=1 and done_o=0:
  - If cnt==HALF_PERIOD-1: cnt<=0 and clk_o<=~clk_o.
  - Otherwise cnt<=cnt+1.
- Period timing: output period = 2*HALF_PERIOD reference cycles, 50% duty. With HALF_PERIOD=1, clk_o toggles every enabled edge (divide-by-2).
- Strobes:
  - rise_o<=1 exactly on the edge where clk_o toggles 0->1; fall_o<=1 exactly on 1->0 toggles.
  - Otherwise both are 0.
  - Strobes are registered and therefore coincide with the new clk_o value.
  - rise_o and fall_o are never high together.
- cycles_o increments on every 0->1 toggle and wraps modulo 2^CYC_W.
- Auto-stop (MAX_CYCLES>0):
  - On the 1->0 toggle that completes period number MAX_CYCLES (i.e. cycles_o==MAX_CYCLES at that edge), done_o<=1.
  - After that, clk_o stays 0 (or the toggled level), cnt holds, strobes stay 0.
  - done_o remains high until reset.
  - MAX_CYCLES=0 never asserts done_o.
- en=0:
  - cnt, clk_o, cycles_o and done_o hold; rise_o/fall_o forced 0.
  - Resuming continues from the held cnt, with no extra or shortened half-period beyond the frozen cycles.
- Reset mid-operation: all outputs return to reset values immediately, regardless of en or done_o.
- INIT_LEVEL=1: the first toggle is 1->0 and produces fall_o. cycles_o counts only subsequent 0->1 toggles.
- Parameter check: HALF_PERIOD==0 is illegal; elaboration must fail with an error.

Test Plan:
- HALF_PERIOD=1, INIT_LEVEL=0, en=1 after reset → clk_o reads 1,0,1,0... on successive edges; rise_o on edges 1,3,5; fall_o on edges 2,4; cycles_o=3 after edge 5.
- HALF_PERIOD=3 → clk_o high for 3 edges, low for 3; first rise at edge 3; cycles_o=2 after 12 edges.
- HALF_PERIOD=2, en dropped for 5 cycles mid half-period (cnt=1) → clk_o and cnt frozen, no strobes; the toggle occurs exactly 1 enabled edge after resume.
- MAX_CYCLES=4, HALF_PERIOD=1 → done_o rises on edge 8 with clk_o=0 and cycles_o=4; no further toggles or strobes for 20 more edges.
- rst_n pulsed low asynchronously between clock edges while clk_o=1, cycles_o=7 → outputs go to 0 immediately without a clock edge; counting restarts from 0 afterwards.
- INIT_LEVEL=1, HALF_PERIOD=1 → clk_o reads 1 after reset; first edge gives clk_o=0 with fall_o=1 and cycles_o=0; second edge gives rise_o=1 and cycles_o=1.
